// File: rtl/periph_pkg.sv
// periph_pkg: shared FSM state type and window/error constants for the peripheral bridge.
package periph_pkg;
  localparam int WIN_W = 16;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_e;
endpackage

// File: rtl/bridge_timer.sv
// bridge_timer: counts cycles while start is high, flags the LIMIT-th cycle, zeroed by clear.
module bridge_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (start && cnt_q != W'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/periph_bridge.sv
// periph_bridge: single-outstanding CPU data bus to register-file bridge with address checks and read timeout.
module periph_bridge
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          RD_TIMEOUT = 16,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              wr_en,
  output logic [3:0]        be,
  output logic [WIN_W-1:0]  wr_addr,
  output logic [31:0]       wdata,
  output logic              rd_en,
  output logic [WIN_W-1:0]  rd_addr,
  input  logic [31:0]       rdata,
  input  logic              rd_rdy
);
  state_e state_q, state_d;
  logic accept, bad, wr_go, rd_go, rsp_ok, rsp_to, expired;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [3:0] be_q, be_d;
  logic [WIN_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  bridge_timer #(.LIMIT(RD_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst),
    .start(state_q == RD_WAIT), .clear(state_q != RD_WAIT),
    .expired(expired)
  );
  assign cpu_gnt = state_q == IDLE;
  // Ready wins over expiry in the last permitted wait cycle.
  always_comb begin
    accept    = cpu_req && cpu_gnt;
    bad       = cpu_addr[31:16] != BASE_ADDR[31:16] || cpu_addr[1:0] != 2'b00;
    wr_go     = accept && !bad && cpu_we;
    rd_go     = accept && !bad && !cpu_we;
    rsp_ok    = state_q == RD_WAIT && rd_rdy;
    rsp_to    = state_q == RD_WAIT && !rd_rdy && expired;
    state_d   = accept ? (bad ? RESP : cpu_we ? WR : RD_REQ)
              : state_q == RD_REQ ? RD_WAIT
              : state_q == RD_WAIT ? ((rd_rdy || expired) ? RESP : RD_WAIT)
              : IDLE;
    wr_en_d   = wr_go && |cpu_be;
    be_d      = wr_go ? cpu_be : '0;
    wr_addr_d = wr_go ? cpu_addr[WIN_W-1:0] : '0;
    wdata_d   = wr_go ? cpu_wdata : '0;
    rd_en_d   = rd_go;
    rd_addr_d = rd_go ? cpu_addr[WIN_W-1:0] : '0;
    err_d     = (accept && bad) || rsp_to;
    rvalid_d  = err_d || wr_go || rsp_ok;
    rdata_d   = err_d ? ERR_DATA : rsp_ok ? rdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      be_q      <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      be_q      <= be_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  assign wr_en      = wr_en_q;
  assign be         = be_q;
  assign wr_addr    = wr_addr_q;
  assign wdata      = wdata_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_err    = err_q;
  assign cpu_rdata  = rdata_q;
endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, base of the 64 KiB peripheral window.
REQ-002 Parameter RD_TIMEOUT, default 16, maximum number of cycles to wait for rd_rdy.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, value of cpu_rdata on an error response.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 cpu_req  in  1  CPU data-access request.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  32  byte address.
REQ-009 cpu_be  in  4  byte enables.
REQ-010 cpu_wdata  in  32  write data.
REQ-011 cpu_gnt  out  1  request accepted this cycle.
REQ-012 cpu_rvalid  out  1  one-cycle response strobe, for reads and writes.
REQ-013 cpu_rdata  out  32  read data, valid with cpu_rvalid.
REQ-014 cpu_err  out  1  error flag, valid with cpu_rvalid.
REQ-015 wr_en / be / wr_addr / wdata  out  1/4/16/32  register-file write port.
REQ-016 rd_en / rd_addr  out  1/16  register-file read port.
REQ-017 rdata / rd_rdy  in  32/1  register-file read data and ready.

Function
REQ-018 The FSM SHALL have states IDLE, WR, RD_REQ, RD_WAIT and RESP.
REQ-019 cpu_gnt SHALL be a combinational output equal to (state==IDLE).
REQ-020 A request SHALL be accepted on an edge where cpu_req && cpu_gnt; addr, we, be and wdata are captured on that edge.
REQ-021 On acceptance, the access SHALL be flagged as an error, with no register-file strobe, if cpu_addr[31:16] != BASE_ADDR[31:16] or cpu_addr[1:0] != 0.
REQ-022 An error access SHALL go to RESP, giving cpu_rvalid=1, cpu_err=1 and cpu_rdata=ERR_DATA in the cycle after acceptance.
REQ-023 A valid write SHALL go to WR: wr_en=1 for exactly one cycle (T+1), with wr_addr=addr[15:0], be and wdata; cpu_rvalid=1 and cpu_err=0 in the same cycle; then return to IDLE.
REQ-024 A write with be==0 SHALL be acknowledged as in REQ-023 but with wr_en held at 0.
REQ-025 A valid read SHALL go to RD_REQ, asserting rd_en=1 for exactly one cycle (T+1) with rd_addr=addr[15:0], then move to RD_WAIT.
REQ-026 In RD_WAIT, when rd_rdy=1 the bridge SHALL register rdata and give cpu_rvalid=1, cpu_err=0 and cpu_rdata=rdata in the next cycle; nominal read latency is acceptance to rvalid = 3 cycles.
REQ-027 If rd_rdy is not seen within RD_TIMEOUT cycles of entering RD_WAIT, the bridge SHALL respond with an error as in REQ-022.
REQ-028 An rd_rdy arriving after a timeout, or outside RD_WAIT, SHALL be ignored.
REQ-029 cpu_rvalid SHALL be a single-cycle pulse; cpu_rdata SHALL be 0 whenever cpu_rvalid=0.
REQ-030 At most one transaction SHALL be outstanding; cpu_req asserted while cpu_gnt=0 SHALL be held off, not dropped.
REQ-031 wr_en and rd_en SHALL never both be 1 in the same cycle.

Reset
REQ-032 While rst=1: state=IDLE, timeout counter=0, and all outputs 0 except cpu_gnt, which follows IDLE (=1).
REQ-033 A reset asserted mid-transaction SHALL abort it with no response, and no strobe SHALL be issued after rst deasserts.

Structure
REQ-034 Package periph_pkg SHALL hold the FSM state enum, the 16-bit window width constant and the ERR_DATA default.
REQ-035 The RD_WAIT timeout counter SHALL be sub-module bridge_timer (inputs: start, clear; output: expired), sized $clog2(RD_TIMEOUT+1).
REQ-036 All outputs except cpu_gnt SHALL be registered.

Verification
REQ-037 Write 0x4000_0004, be=4'b0001, wdata=0x5: wr_en pulses at T+1 with wr_addr=0x4 and wdata=0x5; cpu_rvalid=1, cpu_err=0 at T+1.
REQ-038 Read 0x4000_0000 with a register-file model returning 0x12AB_3400 one cycle after rd_en: cpu_rvalid at T+3 with cpu_rdata=0x12AB_3400.
REQ-039 Read 0x5000_0000 and read 0x4000_0002: no rd_en; cpu_rvalid=1, cpu_err=1, cpu_rdata=0xDEAD_BEEF at T+1.
REQ-040 Read with rd_rdy tied to 0: error response after 16 RD_WAIT cycles; a late rd_rdy is ignored.
REQ-041 Back-to-back requests with cpu_req held high: second request granted only after the first cpu_rvalid; both complete in order.
REQ-042 rst asserted during RD_WAIT: all outputs 0 immediately and no cpu_rvalid afterwards; the next read completes normally.
